tdt_dm_cdc_tx: RTL and testbench



---
 rtl/tdt_dm_cdc_tx_pkg.sv | 25 ++
 rtl/tdt_dm_cdc_ack_sync.sv | 34 +++
 rtl/tdt_dm_cdc_tx.sv | 155 +++++++++++++++
 tb/tb_tdt_dm_cdc_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdt_dm_cdc_tx_pkg.sv
// -----------------------------------------------------------------------------
// tdt_dm_cdc_tx_pkg
// Shared constants for the debug-module toggle-handshake transmitter:
//   - FSM state encodings (IDLE / WAIT_ACK / ERR); ERR is only reachable in
//     the timeout build (TDT_DM_CDC_TX_TIMEOUT_EN).
//   - Default acknowledge synchronizer depth.
//   - ack_matches(): handshake completion test (synchronized ack level
//     equals the request level we last drove).
// -----------------------------------------------------------------------------
package tdt_dm_cdc_tx_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_ACK = 2'd1;
  localparam logic [STATE_W-1:0] ST_ERR      = 2'd2;

  localparam int SYNC_NUM_DEFAULT = 2;

  // A transfer is complete once the destination has echoed our request level.
  function automatic logic ack_matches(input logic ack_sync, input logic req_level);
    return (ack_sync == req_level);
  endfunction

endpackage

// File: rtl/tdt_dm_cdc_ack_sync.sv
// -----------------------------------------------------------------------------
// tdt_dm_cdc_ack_sync
// SYNC_NUM-deep flop chain bringing the asynchronous acknowledge toggle from
// the destination domain into src_clk. Only the last stage is meant to be
// consumed.
//
// Ports:
//   src_clk   in   source clock
//   src_rst   in   synchronous, active-high reset (clears every stage)
//   cdc_ack   in   asynchronous ack toggle level
//   ack_sync  out  synchronized ack level (last stage)
// -----------------------------------------------------------------------------
module tdt_dm_cdc_ack_sync #(
  parameter int SYNC_NUM = 2
) (
  input  logic src_clk,
  input  logic src_rst,
  input  logic cdc_ack,
  output logic ack_sync
);

  logic [SYNC_NUM-1:0] sync_q;

  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_NUM-2:0], cdc_ack};
    end
  end

  assign ack_sync = sync_q[SYNC_NUM-1];

endmodule

// File: rtl/tdt_dm_cdc_tx.sv
// -----------------------------------------------------------------------------
// tdt_dm_cdc_tx
// Source side of the debug-module toggle handshake. A word accepted in IDLE is
// placed on cdc_data and announced by inverting cdc_req on the same edge. The
// transmitter then waits until the synchronized cdc_ack equals cdc_req, pulses
// tx_done and returns to IDLE. The destination only samples cdc_data after its
// own request synchronizer, so the bus is stable long before it is read.
//
// Optional feature: define TDT_DM_CDC_TX_TIMEOUT_EN to bound the ack wait to
// TIMEOUT_CYC cycles. On expiry tx_err pulses and the FSM parks in ERR until
// the late ack arrives, then returns to IDLE without tx_done. Without the
// macro there is no counter, no ERR state and tx_err is tied low.
//
// Handshake: req_vld/req_rdy is a plain valid/ready pair; a word transfers on
// a rising edge where both are high. req_rdy is a decode of the state only,
// req_vld is ignored while req_rdy is low, and req_data is sampled only on the
// accepting edge.
//
// Ports:
//   src_clk    in   sole clock
//   src_rst    in   synchronous, active-high reset
//   req_vld    in   new word offered
//   req_data   in   word to send
//   req_rdy    out  transmitter can accept (IDLE)
//   cdc_req    out  registered request toggle level
//   cdc_data   out  registered, held data bus
//   cdc_ack    in   asynchronous ack toggle from destination
//   tx_done    out  one-cycle pulse: transfer acknowledged
//   tx_err     out  one-cycle pulse: ack timeout (timeout build only)
//   dbg_state  out  current FSM state (ST_* encodings from the package)
// -----------------------------------------------------------------------------
module tdt_dm_cdc_tx
  import tdt_dm_cdc_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_NUM    = SYNC_NUM_DEFAULT,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  src_clk,
  input  logic                  src_rst,
  input  logic                  req_vld,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_rdy,
  output logic                  cdc_req,
  output logic [DATA_WIDTH-1:0] cdc_data,
  input  logic                  cdc_ack,
  output logic                  tx_done,
  output logic                  tx_err,
  output logic [STATE_W-1:0]    dbg_state
);

  // Elaboration-time parameter sanity.
  if (SYNC_NUM < 2) begin : g_bad_sync_num
    $error("tdt_dm_cdc_tx: SYNC_NUM must be at least 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("tdt_dm_cdc_tx: TIMEOUT_CYC must be at least 2");
  end

  logic [STATE_W-1:0]    state_q;
  logic [STATE_W-1:0]    state_d;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ack_sync;
  logic                  ack_match;
  logic                  accept;
  logic                  expire;

  tdt_dm_cdc_ack_sync #(
    .SYNC_NUM (SYNC_NUM)
  ) u_ack_sync (
    .src_clk  (src_clk),
    .src_rst  (src_rst),
    .cdc_ack  (cdc_ack),
    .ack_sync (ack_sync)
  );

  assign ack_match = ack_matches(ack_sync, req_q);
  assign req_rdy   = (state_q == ST_IDLE);
  assign accept    = req_vld && req_rdy;

`ifdef TDT_DM_CDC_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;

  // Cleared on the accepting edge so the first WAIT_ACK cycle sees 0; the FSM
  // leaves WAIT_ACK at TIMEOUT_CYC-1, so the counter never wraps.
  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == ST_WAIT_ACK) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A match in the expiry cycle takes priority: it completes normally.
  assign expire = (state_q == ST_WAIT_ACK) && !ack_match &&
                  (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_match) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        // Late ack closes out the abandoned transfer without reporting it.
        if (ack_match) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      // Data and request move together; nothing else may touch them.
      if (accept) begin
        req_q  <= ~req_q;
        data_q <= req_data;
      end
    end
  end

  // Decoded from registers only (state, synchronizer, counter).
  assign tx_done   = (state_q == ST_WAIT_ACK) && ack_match;
  assign tx_err    = expire;
  assign cdc_req   = req_q;
  assign cdc_data  = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tdt_dm_cdc_tx.sv
module tb_tdt_dm_cdc_tx;
  import tdt_dm_cdc_tx_pkg::*;

  localparam int W           = 32;
  localparam int SYNC_NUM    = 2;
  localparam int TIMEOUT_CYC = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          src_rst = 1'b1;
  logic          req_vld = 1'b0;
  logic [W-1:0]  req_data = '0;
  logic          req_rdy;
  logic          cdc_req;
  logic [W-1:0]  cdc_data;
  logic          cdc_ack;
  logic          tx_done;
  logic          tx_err;
  logic [1:0]    dbg_state;

  logic loop_en = 1'b1;
  logic ack_man = 1'b0;
  assign cdc_ack = loop_en ? cdc_req : ack_man;

  tdt_dm_cdc_tx #(
    .DATA_WIDTH  (W),
    .SYNC_NUM    (SYNC_NUM),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .src_clk   (clk),
    .src_rst   (src_rst),
    .req_vld   (req_vld),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .cdc_req   (cdc_req),
    .cdc_data  (cdc_data),
    .cdc_ack   (cdc_ack),
    .tx_done   (tx_done),
    .tx_err    (tx_err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_req = 1'b0;
  int           checks = 0;
  int           failures = 0;
  int           done_cnt = 0;
  int           err_cnt = 0;

  always @(negedge clk) begin
    if (!src_rst) begin
      if (!req_rdy && exp_q.size() > 0) begin
        checks++;
        if (cdc_data !== exp_q[0]) begin
          failures++;
          $display("FAIL hold_data: cdc_data=%h expected %h", cdc_data, exp_q[0]);
        end
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: tx_done=1 with no outstanding word");
        end else begin
          logic [W-1:0] w;
          w = exp_q.pop_front();
          if (cdc_data !== w) begin
            failures++;
            $display("FAIL done_data: cdc_data=%h expected %h", cdc_data, w);
          end
        end
      end
      if (tx_err === 1'b1) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    src_rst = 1'b1;
    req_vld = 1'b0;
    ack_man = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    src_rst = 1'b0;
    exp_q.delete();
    exp_req = 1'b0;
  endtask

  // Offers one word as soon as req_rdy is high; returns at the negedge of the
  // cycle after acceptance, having checked the toggle and data bus.
  task automatic send(input logic [W-1:0] data);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (req_rdy !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL send_rdy_timeout: req_rdy=%b expected 1", req_rdy);
    end
    req_vld  = 1'b1;
    req_data = data;
    exp_q.push_back(data);
    exp_req = ~exp_req;
    @(posedge clk); #1;
    req_vld  = 1'b0;
    req_data = $urandom();
    @(negedge clk);
    checks++;
    if (cdc_req !== exp_req || cdc_data !== data) begin
      failures++;
      $display("FAIL send_launch: cdc_req=%b cdc_data=%h expected %b %h",
               cdc_req, cdc_data, exp_req, data);
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt !== target) begin
      failures++;
      $display("FAIL wait_done: done_cnt=%0d expected %0d", done_cnt, target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (req_rdy !== 1'b1 || cdc_req !== 1'b0 || cdc_data !== '0 ||
        tx_done !== 1'b0 || tx_err !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_values: rdy=%b req=%b data=%h done=%b err=%b st=%0d expected 1 0 0 0 0 0",
               req_rdy, cdc_req, cdc_data, tx_done, tx_err, dbg_state);
    end
  endtask

  task automatic test_basic();
    int base;
    loop_en = 1'b1;
    base = done_cnt;
    send(32'hDEAD_BEEF);
    for (int k = 0; k < SYNC_NUM - 1; k++) begin
      @(negedge clk);
      checks++;
      if (tx_done !== 1'b0 || req_rdy !== 1'b0) begin
        failures++;
        $display("FAIL basic_early: tx_done=%b req_rdy=%b expected 0 0", tx_done, req_rdy);
      end
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b1) begin
      failures++;
      $display("FAIL basic_done_cycle: tx_done=%b expected 1", tx_done);
    end
    @(negedge clk);
    checks++;
    if (req_rdy !== 1'b1 || tx_done !== 1'b0) begin
      failures++;
      $display("FAIL basic_rdy_back: req_rdy=%b tx_done=%b expected 1 0", req_rdy, tx_done);
    end
    checks++;
    if (done_cnt !== base + 1) begin
      failures++;
      $display("FAIL basic_done_count: %0d expected %0d", done_cnt - base, 1);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    loop_en = 1'b1;
    base = done_cnt;
    send(32'h1);
    send(32'h2);
    send(32'h3);
    wait_done(base + 3);
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== base + 3 || cdc_req !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_total: dones=%0d cdc_req=%b pending=%0d expected 3 1 0",
               done_cnt - base, cdc_req, exp_q.size());
    end
  endtask

  task automatic test_random_words();
    int base;
    loop_en = 1'b1;
    base = done_cnt;
    for (int i = 0; i < 6; i++) begin
      send($urandom());
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_done(base + 6);
  endtask

  task automatic test_ignore_busy();
    int base;
    logic [W-1:0] held;
    logic         lvl;
    base = done_cnt;
    ack_man = cdc_req;
    loop_en = 1'b0;
    held = 32'hA5A5_0001;
    send(held);
    lvl = exp_req;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      req_vld  = 1'b1;
      req_data = 32'h5A5A_0000 + i;
      @(negedge clk);
      checks++;
      if (cdc_data !== held || cdc_req !== lvl || req_rdy !== 1'b0) begin
        failures++;
        $display("FAIL busy_ignore: data=%h req=%b rdy=%b expected %h %b 0",
                 cdc_data, cdc_req, req_rdy, held, lvl);
      end
      @(posedge clk); #1;
    end
    req_vld = 1'b0;
    ack_man = ~ack_man;
    wait_done(base + 1);
    repeat (3) @(negedge clk);
    checks++;
    if (cdc_req !== lvl || done_cnt !== base + 1) begin
      failures++;
      $display("FAIL busy_after: req=%b dones=%0d expected %b 1", cdc_req, done_cnt - base, lvl);
    end
    loop_en = 1'b1;
  endtask

`ifdef TDT_DM_CDC_TX_TIMEOUT_EN
  task automatic test_timeout();
    int base_d;
    int base_e;
    int n;
    base_d = done_cnt;
    base_e = err_cnt;
    ack_man = cdc_req;
    loop_en = 1'b0;
    send(32'hC0DE_0010);
    // send() returned in WAIT_ACK cycle 1; walk cycles 2..TIMEOUT_CYC+1.
    for (int k = 2; k <= TIMEOUT_CYC + 1; k++) begin
      @(negedge clk);
      checks++;
      if (tx_err !== (k == TIMEOUT_CYC) || req_rdy !== 1'b0) begin
        failures++;
        $display("FAIL timeout_err_cycle: wait_cycle=%0d tx_err=%b req_rdy=%b expected %b 0",
                 k, tx_err, req_rdy, (k == TIMEOUT_CYC));
      end
    end
    repeat (9) @(negedge clk);
    checks++;
    if (req_rdy !== 1'b0 || err_cnt !== base_e + 1 || dbg_state !== ST_ERR) begin
      failures++;
      $display("FAIL timeout_parked: rdy=%b errs=%0d st=%0d expected 0 1 %0d",
               req_rdy, err_cnt - base_e, dbg_state, ST_ERR);
    end
    ack_man = ~ack_man;
    n = 0;
    while (req_rdy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_rdy !== 1'b1 || done_cnt !== base_d || err_cnt !== base_e + 1) begin
      failures++;
      $display("FAIL timeout_recover: rdy=%b dones=%0d errs=%0d expected 1 0 1",
               req_rdy, done_cnt - base_d, err_cnt - base_e);
    end
    exp_q.delete();
    loop_en = 1'b1;
  endtask
`else
  task automatic test_no_timeout();
    int base_d;
    int base_e;
    base_d = done_cnt;
    base_e = err_cnt;
    ack_man = cdc_req;
    loop_en = 1'b0;
    send(32'h0BAD_F00D);
    repeat (5000) @(negedge clk);
    checks++;
    if (err_cnt !== base_e || tx_err !== 1'b0 || dbg_state !== ST_WAIT_ACK ||
        req_rdy !== 1'b0 || done_cnt !== base_d) begin
      failures++;
      $display("FAIL no_timeout_wait: errs=%0d st=%0d rdy=%b dones=%0d expected 0 %0d 0 0",
               err_cnt - base_e, dbg_state, req_rdy, done_cnt - base_d, ST_WAIT_ACK);
    end
    ack_man = ~ack_man;
    wait_done(base_d + 1);
    loop_en = 1'b1;
  endtask
`endif

  task automatic test_reset_mid();
    int base_d;
    int base_e;
    ack_man = cdc_req;
    loop_en = 1'b0;
    send(32'hFEED_1234);
    @(posedge clk); #1;
    src_rst = 1'b1;
    ack_man = 1'b0;
    base_d = done_cnt;
    base_e = err_cnt;
    @(posedge clk); #1;
    src_rst = 1'b0;
    exp_q.delete();
    exp_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cdc_req !== 1'b0 || cdc_data !== '0 || req_rdy !== 1'b1 ||
        tx_done !== 1'b0 || tx_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: req=%b data=%h rdy=%b done=%b err=%b expected 0 0 1 0 0",
               cdc_req, cdc_data, req_rdy, tx_done, tx_err);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== base_d || err_cnt !== base_e) begin
      failures++;
      $display("FAIL reset_mid_quiet: dones=%0d errs=%0d expected 0 0",
               done_cnt - base_d, err_cnt - base_e);
    end
    loop_en = 1'b1;
    // Clean transfer after reset proves the toggle restarted from 0.
    base_d = done_cnt;
    send(32'h7777_0001);
    wait_done(base_d + 1);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random_words();
    test_ignore_busy();
`ifdef TDT_DM_CDC_TX_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_queue: pending=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
